instr_prefetch_buffer: RTL and testbench

Fetch stage sitting directly upstream of the CPU datapath.
- Owns the fetch PC and issues word requests to a latency-variable instruction memory.
- Buffers returned words with their PCs in a small FIFO and hands them to decode through a valid/ready handshake.
- On a redirect from branch, jump or jr, flushes all buffered and in-flight fetches and restarts at the target.

---
 rtl/ifetch_pkg.sv | 33 +++
 rtl/ifb_fifo.sv | 70 +++++++
 rtl/instr_prefetch_buffer.sv | 174 +++++++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
// Shared types and constants for the instruction prefetch buffer.
//   INSTR_W / ADDR_W : instruction and address widths
//   PC_STEP          : byte distance between consecutive instruction words
//   NOP_INSTR        : value presented on the instruction bus when idle
//   state_t          : fetch FSM encoding (RUN, FLUSH)
//   fifo_entry_t     : one buffered instruction with its PC
//   word_align()     : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package ifetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  PC_STEP   = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fifo_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/ifb_fifo.sv
// ---------------------------------------------------------------------------
// ifb_fifo
// Small synchronous FIFO of fetched instructions. The head entry is read
// combinationally so decode sees it in the same cycle it becomes valid.
// DEPTH must be a power of two (pointers wrap naturally), at least 2.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   clear             : drop all entries (wins over push and pop)
//   push, push_data   : write one entry at the tail
//   pop               : remove the head entry
//   head              : current head entry
//   count, full, empty: occupancy status
// ---------------------------------------------------------------------------
module ifb_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  fifo_entry_t              push_data,
  input  logic                     pop,
  output fifo_entry_t              head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             wr_en, rd_en;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign head  = mem[rd_ptr_reg];

  assign wr_en = push && !full && !clear;
  assign rd_en = pop && !empty && !clear;

  // Storage carries no reset; only pointers and occupancy need one.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(wr_en);
      rd_ptr_reg <= rd_ptr_reg + PTR_W'(rd_en);
      count_reg  <= count_reg + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// instr_prefetch_buffer
// Fetch stage in front of the CPU datapath. Owns the fetch PC, issues word
// requests to a variable-latency instruction memory, buffers returned words
// with their PCs and hands them to decode over valid/ready. A redirect
// flushes buffered and in-flight fetches and restarts at the target.
//
// Optional feature (macro PREFETCH_BYPASS_EN): when the FIFO is empty and a
// live response arrives, it is presented to decode combinationally in the
// same cycle; it is pushed only if decode does not take it.
//
// Parameters: DEPTH (FIFO entries and credit cap, power of two >= 2),
//             RESET_PC (first fetch address).
// Ports:
//   clk_i, rst_i                  : clock, asynchronous active-low reset
//   imem_req_o/addr_o/gnt_i       : request channel to instruction memory
//   imem_rvalid_i/rdata_i         : in-order response channel
//   instr_valid_o/instr_o/
//   instr_pc_o/pc_plus4_o/
//   instr_ready_i                 : handshake to decode
//   redirect_i/redirect_pc_i      : flush and restart fetch
// ---------------------------------------------------------------------------
module instr_prefetch_buffer
  import ifetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  output logic [ADDR_W-1:0]  pc_plus4_o,
  input  logic               instr_ready_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i
);

  localparam int unsigned       CNT_W        = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]    CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] START_PC     = word_align(RESET_PC);

  state_t            state_reg, state_next;
  logic              req_en_reg;
  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] resp_pc_reg, resp_pc_next;
  logic [CNT_W-1:0]  outstanding_reg, outstanding_next;
  logic [CNT_W-1:0]  discard_reg, discard_next;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  fifo_entry_t       fifo_head, push_entry, out_entry;

  logic [CNT_W:0]    credit_used;
  logic              grant, resp_ok, resp_accept, bypass_hit;

  // Buffered plus in-flight words never exceed DEPTH, so every accepted
  // response is guaranteed a FIFO slot.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_reg};

  // req_en_reg holds off the first request until one clock after reset
  // release.
  assign imem_req_o  = req_en_reg && (state_reg == RUN) && (credit_used < CREDIT_LIMIT);
  assign imem_addr_o = fetch_pc_reg;
  assign grant       = imem_req_o && imem_gnt_i;

  // A response with nothing outstanding cannot belong to us; ignoring it
  // keeps the counters from wrapping.
  assign resp_ok     = imem_rvalid_i && (outstanding_reg != '0);
  assign resp_accept = resp_ok && (discard_reg == '0);

`ifdef PREFETCH_BYPASS_EN
  assign bypass_hit = resp_accept && fifo_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  assign push_entry = '{instr: imem_rdata_i, pc: resp_pc_reg};

  // Redirect wins over a same-cycle push; a bypassed word taken by decode
  // never enters the FIFO.
  assign fifo_push = resp_accept && !redirect_i && !(bypass_hit && instr_ready_i);
  assign fifo_pop  = !fifo_empty && instr_ready_i;

  ifb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .clear     (redirect_i),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Idle outputs are forced to a known value rather than exposing stale RAM.
  always_comb begin
    out_entry = '{instr: NOP_INSTR, pc: '0};
    if (!fifo_empty) begin
      out_entry = fifo_head;
    end else if (bypass_hit) begin
      out_entry = push_entry;
    end
  end

  assign instr_valid_o = !fifo_empty || bypass_hit;
  assign instr_o       = out_entry.instr;
  assign instr_pc_o    = out_entry.pc;
  assign pc_plus4_o    = out_entry.pc + PC_STEP;

  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    discard_next     = discard_reg;
    outstanding_next = outstanding_reg + CNT_W'(grant) - CNT_W'(resp_ok);

    if (grant) begin
      fetch_pc_next = fetch_pc_reg + PC_STEP;
    end
    if (resp_accept) begin
      resp_pc_next = resp_pc_reg + PC_STEP;
    end
    if (resp_ok && (discard_reg != '0)) begin
      discard_next = discard_reg - CNT_W'(1);
    end
    if ((state_reg == FLUSH) && (discard_next == '0)) begin
      state_next = RUN;
    end

    // Every request still in flight after this edge (including a same-cycle
    // grant) belongs to the old path. During FLUSH all outstanding requests
    // are already marked for discard, so the outstanding count is also the
    // accumulated discard total.
    if (redirect_i) begin
      fetch_pc_next = word_align(redirect_pc_i);
      resp_pc_next  = word_align(redirect_pc_i);
      discard_next  = outstanding_next;
      state_next    = (outstanding_next != '0) ? FLUSH : RUN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg       <= RUN;
      req_en_reg      <= 1'b0;
      fetch_pc_reg    <= START_PC;
      resp_pc_reg     <= START_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      req_en_reg      <= 1'b1;
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(fifo_push && fifo_full));

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
`timescale 1ns/100ps
module tb_instr_prefetch_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [31:0] pc_plus4_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .instr_ready_i (instr_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endfunction

  // Memory contents: a simple address-derived pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory model state and logs
  int          mem_lat   = 2;
  bit          gnt_block = 1'b0;
  int          cyc       = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] grant_q[$];
  logic [31:0] cons_q[$];
  int          resp_cnt = 0;
  int          max_if   = 0;

  // Behavioural model: counts of words in flight, words to drop, words held,
  // and the next address expected on the request and decode sides.
  int          out_m, disc_m, buf_m;
  logic [31:0] exp_fetch, exp_dec;
  bit          started;

  always @(negedge clk_i) begin
    bit exp_req, exp_valid, g, r, p, acc;
    #1;
    if (!rst_i) begin
      pend_addr.delete();
      pend_due.delete();
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      out_m = 0; disc_m = 0; buf_m = 0; max_if = 0;
      exp_fetch = RESET_PC; exp_dec = RESET_PC;
      started = 1'b0;
    end else begin
      cyc++;
      imem_gnt_i = !gnt_block;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(pend_addr[0]);
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'hDEAD_BEEF;
      end
      #2;
      // Expected outputs for this cycle
      exp_req = started && (disc_m == 0) && ((buf_m + out_m) < DEPTH);
`ifdef PREFETCH_BYPASS_EN
      exp_valid = (buf_m > 0) || ((disc_m == 0) && imem_rvalid_i);
`else
      exp_valid = (buf_m > 0);
`endif
      chk("req", imem_req_o, exp_req);
      if (exp_req) chk("addr", imem_addr_o, exp_fetch);
      chk("valid", instr_valid_o, exp_valid);
      if (exp_valid) begin
        chk("pc", instr_pc_o, exp_dec);
        chk("instr", instr_o, mem_word(exp_dec));
        chk("pc_plus4", pc_plus4_o, exp_dec + 32'd4);
      end
      // Transaction logs (from the DUT side)
      if (instr_valid_o && instr_ready_i) begin
        cons_q.push_back(instr_pc_o);
        $display("decode pc=%08h instr=%08h redirect=%0d", instr_pc_o, instr_o, redirect_i);
      end
      if (imem_req_o && imem_gnt_i) begin
        grant_q.push_back(imem_addr_o);
        pend_addr.push_back(imem_addr_o);
        pend_due.push_back(cyc + mem_lat);
      end
      if (imem_rvalid_i) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
        resp_cnt++;
      end
      // Model update for the coming edge
      g = exp_req && imem_gnt_i;
      r = imem_rvalid_i;
      p = exp_valid && instr_ready_i;
      out_m = out_m + int'(g) - int'(r);
      if (redirect_i) begin
        disc_m    = out_m;
        buf_m     = 0;
        exp_fetch = redirect_pc_i & ~32'd3;
        exp_dec   = redirect_pc_i & ~32'd3;
      end else begin
        acc = r && (disc_m == 0);
        if (r && disc_m > 0) disc_m--;
        buf_m = buf_m + int'(acc) - int'(p);
        if (p) exp_dec = exp_dec + 32'd4;
        if (g) exp_fetch = exp_fetch + 32'd4;
      end
      started = 1'b1;
      if (pend_addr.size() + buf_m > max_if) max_if = pend_addr.size() + buf_m;
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_req"}, imem_req_o, 32'd0);
    chk({tag, "_addr"}, imem_addr_o, RESET_PC);
    chk({tag, "_valid"}, instr_valid_o, 32'd0);
    chk({tag, "_instr"}, instr_o, 32'd0);
    chk({tag, "_pc"}, instr_pc_o, 32'd0);
    chk({tag, "_pc_plus4"}, pc_plus4_o, 32'd4);
  endtask

  task automatic do_reset(input bit ready, input int lat);
    @(negedge clk_i);
    rst_i = 1'b0; redirect_i = 1'b0; gnt_block = 1'b0;
    instr_ready_i = ready; mem_lat = lat;
    repeat (2) @(negedge clk_i);
    cons_q.delete(); grant_q.delete(); resp_cnt = 0;
    rst_i = 1'b1;
  endtask

  task automatic wait_pending(input int n, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk_i);
      if (pend_addr.size() == n) hit = 1'b1;
    end
    chk({tag, "_pending_reached"}, 32'(hit), 32'd1);
  endtask

  task automatic wait_new_grant(input int g0, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk_i);
      if (grant_q.size() > g0) hit = 1'b1;
    end
    chk({tag, "_grant_seen"}, 32'(hit), 32'd1);
  endtask

  initial begin
    int r0, g0, c0;
    logic [31:0] saved;
    bit hit;
    rst_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b1;

    // Reset values while held in reset
    repeat (3) @(negedge clk_i);
    #4 check_reset("rst");

    // 1: streaming with 2-cycle memory and ready=1
    do_reset(1'b1, 2);
    repeat (20) @(negedge clk_i);
    chk("t1_grants", 32'(grant_q.size() >= 3), 32'd1);
    chk("t1_grant0", grant_q[0], 32'h0);
    chk("t1_grant1", grant_q[1], 32'h4);
    chk("t1_grant2", grant_q[2], 32'h8);
    chk("t1_decodes", 32'(cons_q.size() >= 3), 32'd1);
    chk("t1_dec0", cons_q[0], 32'h0);
    chk("t1_dec1", cons_q[1], 32'h4);
    chk("t1_dec2", cons_q[2], 32'h8);
    chk("t1_max_inflight", 32'(max_if <= DEPTH), 32'd1);

    // 2: decode stalls, buffer fills, then drains
    do_reset(1'b0, 2);
    repeat (20) @(negedge clk_i);
    #3;
    chk("t2_valid", instr_valid_o, 32'd1);
    chk("t2_head_pc", instr_pc_o, 32'h0);
    chk("t2_req_off", imem_req_o, 32'd0);
    chk("t2_grants", grant_q.size(), 32'd4);
    chk("t2_model_buf", buf_m, 32'd4);
    @(negedge clk_i);
    instr_ready_i = 1'b1;
    repeat (10) @(negedge clk_i);
    chk("t2_drained", 32'(cons_q.size() >= 4), 32'd1);
    chk("t2_dec0", cons_q[0], 32'h0);
    chk("t2_dec1", cons_q[1], 32'h4);
    chk("t2_dec2", cons_q[2], 32'h8);
    chk("t2_dec3", cons_q[3], 32'hC);
    chk("t2_resume", grant_q[4], 32'h10);

    // 3: redirect with 3 requests outstanding
    do_reset(1'b1, 6);
    wait_pending(3, "t3");
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103; gnt_block = 1'b1;
    r0 = resp_cnt; g0 = grant_q.size();
    @(negedge clk_i);
    redirect_i = 1'b0; gnt_block = 1'b0;
    c0 = cons_q.size();
    wait_new_grant(g0, "t3");
    chk("t3_new_addr", grant_q[g0], 32'h100);
    chk("t3_discarded", resp_cnt - r0, 32'd3);
    repeat (12) @(negedge clk_i);
    chk("t3_decoded", 32'(cons_q.size() > c0), 32'd1);
    chk("t3_first_pc", cons_q[c0], 32'h100);

    // 4: redirect in the same cycle as pop and rvalid
    do_reset(1'b1, 2);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk_i);
      #2;
      if (instr_valid_o && imem_rvalid_i) hit = 1'b1;
    end
    chk("t4_collision_found", 32'(hit), 32'd1);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    @(negedge clk_i);
    redirect_i = 1'b0;
    c0 = cons_q.size(); g0 = grant_q.size();
    #3 chk("t4_valid_after", instr_valid_o, 32'd0);
    repeat (12) @(negedge clk_i);
    chk("t4_new_addr", grant_q[g0], 32'h200);
    chk("t4_first_pc", cons_q[c0], 32'h200);

    // 5: grant withheld for 5 cycles
    do_reset(1'b1, 2);
    repeat (6) @(negedge clk_i);
    gnt_block = 1'b1;
    #3;
    saved = imem_addr_o;
    chk("t5_req", imem_req_o, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      #3 chk("t5_addr_stable", imem_addr_o, saved);
    end
    @(negedge clk_i);
    gnt_block = 1'b0;
    @(negedge clk_i);
    #3 chk("t5_addr_step", imem_addr_o, saved + 32'd4);

    // 6: asynchronous reset during a flush
    do_reset(1'b1, 6);
    wait_pending(3, "t6");
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0040; gnt_block = 1'b1;
    @(negedge clk_i);
    redirect_i = 1'b0; gnt_block = 1'b0;
    @(negedge clk_i);
    #3 chk("t6_flush_no_req", imem_req_o, 32'd0);
    #0.5 rst_i = 1'b0;
    #0.5 check_reset("t6_async");
    mem_lat = 2;
    repeat (2) @(negedge clk_i);
    cons_q.delete(); grant_q.delete(); resp_cnt = 0;
    rst_i = 1'b1;
    repeat (12) @(negedge clk_i);
    chk("t6_restart_grant", grant_q[0], RESET_PC);
    chk("t6_restart_dec", cons_q[0], RESET_PC);
    chk("t6_decoded", 32'(cons_q.size() >= 1), 32'd1);

    repeat (3) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
